// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    StRun     = 1'b0,
    StMemWait = 1'b1
  } phc_state_e;

  localparam logic [4:0] RegX0 = 5'd0;

  function automatic logic src_hit(logic use_src, logic [4:0] rs, logic [4:0] rd);
    return use_src && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Enable-gated performance counter, wraps modulo 2^CNT_W, synchronous reset.
module pipe_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush/redirect controller: memory wait > taken redirect > load-use.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             mem_req_valid,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_stall,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] cnt_lu_stall,
  output logic [CNT_W-1:0] cnt_mem_stall,
  output logic [CNT_W-1:0] cnt_redirect
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  phc_state_e       state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             timeout_q, timeout_d;

  logic mem_wait, redirect, load_use;
  logic lu_evt, redir_evt;

  // Hazards are masked during reset so every control output reads 0.
  assign mem_wait = ~rst & mem_req_valid & ~mem_ready;
  assign redirect = ~rst & ex_valid & branch_taken;
  assign load_use = ~rst & ex_valid & ex_is_load & (ex_rd != RegX0) & id_valid &
                    (src_hit(id_use_rs1, id_rs1, ex_rd) | src_hit(id_use_rs2, id_rs2, ex_rd));

  assign redir_evt = redirect & ~mem_wait;
  assign lu_evt    = load_use & ~mem_wait & ~redirect;

  always_comb begin
    pc_stall       = 1'b0;
    if_id_stall    = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    ex_mem_stall   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (mem_wait) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      ex_mem_stall = 1'b1;
    end else if (redirect) begin
      redirect_valid = 1'b1;
      redirect_pc    = branch_target;
      if_id_flush    = 1'b1;
      id_ex_bubble   = 1'b1;
    end else if (load_use) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  always_comb begin
    state_d   = mem_wait ? StMemWait : StRun;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    if (mem_wait) begin
      // The first wait cycle comes from RUN; it restarts the count at 1.
      if (state_q == StRun) begin
        wait_d = WaitW'(1);
      end else if (wait_q != WaitW'(MEM_TIMEOUT)) begin
        wait_d = wait_q + 1'b1;
      end
      if ((MEM_TIMEOUT != 0) && (wait_d == WaitW'(MEM_TIMEOUT))) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_cnt_lu (
    .clk   (clk),
    .rst   (rst),
    .en_i  (lu_evt),
    .cnt_o (cnt_lu_stall)
  );

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_cnt_mem (
    .clk   (clk),
    .rst   (rst),
    .en_i  (mem_wait),
    .cnt_o (cnt_mem_stall)
  );

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_cnt_redir (
    .clk   (clk),
    .rst   (rst),
    .en_i  (redir_evt),
    .cnt_o (cnt_redirect)
  );

endmodule
